// File: rtl/ysyx_22040237_pkg.sv
// Shared types and constants for the ysyx_22040237 instruction fetch unit.
package ysyx_22040237_pkg;

    localparam int unsigned IFU_XLEN     = 64;
    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the PC, fetches over req/gnt/rvalid, hands {pc, inst} to decode.
// Optional YSYX_22040237_IFU_MISALIGN_CHK_EN reports misaligned redirect targets as a fault.
module ysyx_22040237_ifu
    import ysyx_22040237_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    ,
    output logic            out_fault
`endif
);

    ifu_state_e      r_state;
    ifu_state_e      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            r_imem_req;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] w_out_pc_nxt;
    logic [31:0]     r_out_inst;
    logic [31:0]     w_out_inst_nxt;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    logic            r_fault;
    logic            w_fault_nxt;
    logic            w_misalign;

    assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    // Next-state, PC, drop flag and output payload
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_out_pc_nxt   = r_out_pc;
        w_out_inst_nxt = r_out_inst;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
        w_fault_nxt    = r_fault;
`endif
        case (r_state)
            IFU_IDLE: begin
                w_state_nxt = IFU_REQ;
                if (redirect_valid) w_pc_nxt = redirect_pc;
            end
            IFU_REQ: begin
                if (imem_gnt) w_state_nxt = IFU_WAIT;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    if (imem_gnt) w_drop_nxt = 1'b1;
                end
            end
            IFU_WAIT: begin
                if (imem_rvalid) begin
                    w_drop_nxt = 1'b0;
                    if (r_drop || redirect_valid) begin
                        w_state_nxt = IFU_REQ;
                    end else begin
                        w_state_nxt    = IFU_HOLD;
                        w_out_pc_nxt   = r_pc;
                        w_out_inst_nxt = imem_rdata;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
                        w_fault_nxt    = 1'b0;
`endif
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
                if (redirect_valid) w_pc_nxt = redirect_pc;
            end
            IFU_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = IFU_REQ;
                end else if (out_ready) begin
                    w_pc_nxt    = r_pc + XLEN'(4);
                    w_state_nxt = IFU_REQ;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
                    w_fault_nxt = 1'b0;
`endif
                end
            end
            default: w_state_nxt = IFU_IDLE;
        endcase
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
        // A stale response can land outside WAIT once a fault has cut the fetch short
        if (r_state != IFU_WAIT && imem_rvalid) w_drop_nxt = 1'b0;
        if (r_state != IFU_IDLE && w_misalign) begin
            w_state_nxt    = IFU_HOLD;
            w_pc_nxt       = redirect_pc;
            w_out_pc_nxt   = redirect_pc;
            w_out_inst_nxt = INST_NOP;
            w_fault_nxt    = 1'b1;
            w_drop_nxt     = ((r_state == IFU_REQ) && imem_gnt)
                          || ((r_state == IFU_WAIT) && !imem_rvalid)
                          || (r_drop && !imem_rvalid);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IFU_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_imem_req  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
            r_fault     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_imem_req  <= (w_state_nxt == IFU_REQ);
            r_out_valid <= (w_state_nxt == IFU_HOLD);
            r_out_pc    <= w_out_pc_nxt;
            r_out_inst  <= w_out_inst_nxt;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
            r_fault     <= w_fault_nxt;
`endif
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    assign out_fault = r_fault;
`endif

`ifndef SYNTHESIS
    // Memory must only answer while a fetch is outstanding
    always @(posedge clk) begin
        assert (rst || !imem_rvalid || r_state == IFU_WAIT || r_drop)
            else $error("imem_rvalid with no outstanding fetch");
    end
`endif

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Randomized bench for ysyx_22040237_ifu against a PC-stream scoreboard and a latency-randomized memory.
module tb_ysyx_22040237_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    logic        out_fault;
`endif

    ysyx_22040237_ifu u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
        ,
        .out_fault      (out_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          gnt_pct;
    int          dly_max;
    int          rdy_pct;
    int          redir_pct;
    bit          force_redir;
    bit          force_rdy;
    logic [63:0] force_tgt;
    bit          pending;
    int          cnt;
    logic [63:0] paddr;
    logic [63:0] exp_pc;
    bit          chk_hold;
    bit          chk_req;
    logic [63:0] prev_out_pc;
    logic [31:0] prev_out_inst;
    logic [63:0] prev_addr;
    logic [63:0] hs_pc[$];
    int          hs_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Instruction word stored at an address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] t;
        t = a[31:0] * 32'h9E37_79B1;
        return t ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // One cycle: check outputs seen at negedge, drive inputs, advance the reference model
    task automatic step();
        bit          hs;
        logic [31:0] exp_inst;
        @(negedge clk);
        cyc++;
        if (chk_hold) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_pc", out_pc, prev_out_pc);
            check("hold_inst", 64'(out_inst), 64'(prev_out_inst));
        end
        if (chk_req) begin
            check("req_held", 64'(imem_req), 64'd1);
            check("req_addr_stable", imem_addr, prev_addr);
        end
        if (imem_req) check("req_addr", imem_addr, exp_pc);
        if (out_valid) check("no_req_in_hold", 64'(imem_req), 64'd0);

        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pending     = 1'b0;
            end
        end
        imem_gnt = 1'b0;
        if (imem_req && !pending && int'($urandom_range(99, 0)) < gnt_pct) begin
            imem_gnt = 1'b1;
            pending  = 1'b1;
            cnt      = int'($urandom_range(dly_max, 1));
            paddr    = imem_addr;
        end
        redirect_valid = force_redir || (int'($urandom_range(99, 0)) < redir_pct);
        redirect_pc    = force_redir ? force_tgt
                                     : RST_PC + 64'($urandom_range(255, 0) * 4);
        out_ready      = force_rdy || (int'($urandom_range(99, 0)) < rdy_pct);

        hs = out_valid && out_ready && !redirect_valid;
        if (hs) begin
            exp_inst = mem_word(exp_pc);
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
            if (exp_pc[1:0] != 2'b00) exp_inst = 32'h0000_0013;
`endif
            check("out_pc", out_pc, exp_pc);
            check("out_inst", 64'(out_inst), 64'(exp_inst));
            hs_pc.push_back(out_pc);
            hs_cyc.push_back(cyc);
            exp_pc = exp_pc + 64'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        chk_hold      = out_valid && !out_ready && !redirect_valid;
        prev_out_pc   = out_pc;
        prev_out_inst = out_inst;
        chk_req       = imem_req && !imem_gnt && !redirect_valid;
        prev_addr     = imem_addr;
    endtask

    task automatic do_reset(input bit late_rvalid);
        @(negedge clk);
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        pending        = 1'b0;
        chk_hold       = 1'b0;
        chk_req        = 1'b0;
        exp_pc         = RST_PC;
        hs_pc.delete();
        hs_cyc.delete();
        @(negedge clk);
        if (late_rvalid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            imem_rvalid = 1'b0;
        end
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_hs(input int n_target, input string tag);
        for (int k = 0; k < 300 && hs_pc.size() < n_target; k++) step();
        check(tag, 64'(hs_pc.size() >= n_target), 64'd1);
    endtask

    task automatic set_knobs(input int g, input int d, input int r, input int rd);
        gnt_pct   = g;
        dly_max   = d;
        rdy_pct   = r;
        redir_pct = rd;
    endtask

    initial begin
        int t_req;
        int t_ov;
        int n;
        bit hit;
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        force_redir = 1'b0; force_rdy = 1'b0; force_tgt = '0;
        set_knobs(100, 1, 100, 0);
        do_reset(1'b0);

        // Latency and back-to-back stream
        t_req = -1; t_ov = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (imem_req && t_req < 0) t_req = cyc;
            if (out_valid && t_ov < 0) t_ov = cyc;
        end
        check("first_req_cycle", 64'(t_req), 64'd1);
        check("req_to_valid", 64'(t_ov - t_req), 64'd2);
        wait_hs(3, "stream_timeout");
        if (hs_pc.size() >= 3) begin
            check("stream_pc0", hs_pc[0], 64'h8000_0000);
            check("stream_pc1", hs_pc[1], 64'h8000_0004);
            check("stream_pc2", hs_pc[2], 64'h8000_0008);
            check("stream_gap", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        end

        // Stall in HOLD for 5 cycles
        set_knobs(100, 1, 0, 0);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin step(); hit = out_valid; end
        check("hold_reached", 64'(hit), 64'd1);
        repeat (5) step();
        check("hold_still_valid", 64'(out_valid), 64'd1);

        // Redirect while a fetch is in flight
        set_knobs(100, 3, 100, 0);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin step(); hit = pending; end
        check("wait_reached", 64'(hit), 64'd1);
        n = hs_pc.size();
        force_redir = 1'b1; force_tgt = 64'h8000_0100;
        step();
        force_redir = 1'b0;
        wait_hs(n + 1, "redir_wait_timeout");
        if (hs_pc.size() > n) check("redir_wait_pc", hs_pc[n], 64'h8000_0100);

        // Redirect beats a simultaneous handshake
        set_knobs(100, 1, 0, 0);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin step(); hit = out_valid; end
        check("hold_reached2", 64'(hit), 64'd1);
        n = hs_pc.size();
        force_redir = 1'b1; force_rdy = 1'b1; force_tgt = 64'h8000_0200;
        step();
        force_redir = 1'b0; force_rdy = 1'b0;
        set_knobs(100, 1, 100, 0);
        wait_hs(n + 1, "redir_hold_timeout");
        if (hs_pc.size() > n) check("redir_hold_pc", hs_pc[n], 64'h8000_0200);

        // Reset during WAIT with a late response
        set_knobs(100, 3, 100, 0);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin step(); hit = pending; end
        check("wait_reached2", 64'(hit), 64'd1);
        do_reset(1'b1);
        set_knobs(100, 1, 100, 0);
        wait_hs(2, "post_rst_timeout");
        if (hs_pc.size() >= 2) begin
            check("post_rst_pc0", hs_pc[0], 64'h8000_0000);
            check("post_rst_pc1", hs_pc[1], 64'h8000_0004);
        end

        // PC wraps modulo 2^64
        n = hs_pc.size();
        force_redir = 1'b1; force_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        force_redir = 1'b0;
        wait_hs(n + 2, "wrap_timeout");
        if (hs_pc.size() >= n + 2) begin
            check("wrap_pc0", hs_pc[n], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_pc1", hs_pc[n + 1], 64'd0);
        end

        // Random traffic
        set_knobs(60, 3, 60, 5);
        n = hs_pc.size();
        repeat (3000) step();
        check("random_progress", 64'(hs_pc.size() > n + 50), 64'd1);

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
        set_knobs(100, 1, 0, 0);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin step(); hit = out_valid && !pending; end
        check("hold_reached3", 64'(hit), 64'd1);
        force_redir = 1'b1; force_tgt = 64'h8000_0102;
        step();
        force_redir = 1'b0;
        @(posedge clk); #1;
        check("fault_valid", 64'(out_valid), 64'd1);
        check("fault_flag", 64'(out_fault), 64'd1);
        check("fault_pc", out_pc, 64'h8000_0102);
        check("fault_inst", 64'(out_inst), 64'h13);
        set_knobs(100, 1, 100, 0);
        n = hs_pc.size();
        wait_hs(n + 1, "fault_hs_timeout");
        force_redir = 1'b1; force_tgt = 64'h8000_0000;
        step();
        force_redir = 1'b0;
        repeat (10) step();
`endif

        // Drain to a quiet point
        set_knobs(100, 1, 100, 0);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
